// File: rtl/board_ram_arbiter_if.sv
// Requester and RAM-side signals of the board RAM arbiter.
// The slave modport is the arbiter; master is the surrounding video/game/RAM logic.
interface board_ram_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 3
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    logic          game_req;
    logic          game_we;
    logic [AW-1:0] game_addr;
    logic [DW-1:0] game_wdata;
    logic          game_gnt;
    logic          game_rvalid;
    logic [DW-1:0] game_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          addr_err;

    modport slave (
        input  vid_req, vid_addr, game_req, game_we, game_addr, game_wdata, ram_rdata,
        output vid_gnt, vid_rvalid, vid_rdata, game_gnt, game_rvalid, game_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, addr_err
    );

    modport master (
        output vid_req, vid_addr, game_req, game_we, game_addr, game_wdata, ram_rdata,
        input  vid_gnt, vid_rvalid, vid_rdata, game_gnt, game_rvalid, game_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, addr_err
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// Shares the single-port board RAM between video scan-out (priority) and game logic,
// with a starvation limit for the game and a fixed 3-cycle read return path.
module board_ram_arbiter #(
    parameter int unsigned CELLS      = 200,
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 3,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic              clk_pix,
    input logic              rst,
    board_ram_arbiter_if.slave bus
);
    typedef struct packed {
        logic valid;
        logic owner;  // 1 = game
        logic oor;
    } tag_t;

    logic [3:0]    starve_cnt;
    tag_t          tag1, tag2;
    logic          vid_gnt, game_gnt, any_gnt;
    logic [AW-1:0] sel_addr;
    logic          sel_we, sel_oor;
    logic [DW-1:0] ret_data;

    always_comb begin
        vid_gnt  = 1'b0;
        game_gnt = 1'b0;
        if (!rst) begin
            if (bus.game_req && (!bus.vid_req || starve_cnt == 4'(STARVE_MAX))) begin
                game_gnt = 1'b1;
            end else if (bus.vid_req) begin
                vid_gnt = 1'b1;
            end
        end
    end

    assign any_gnt  = vid_gnt | game_gnt;
    assign sel_addr = game_gnt ? bus.game_addr : bus.vid_addr;
    assign sel_we   = game_gnt & bus.game_we;
    assign sel_oor  = 32'(sel_addr) >= CELLS;
    assign ret_data = tag2.oor ? '0 : bus.ram_rdata;

    assign bus.vid_gnt  = vid_gnt;
    assign bus.game_gnt = game_gnt;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            bus.ram_en      <= 1'b0;
            bus.ram_we      <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_wdata   <= '0;
            bus.vid_rvalid  <= 1'b0;
            bus.vid_rdata   <= '0;
            bus.game_rvalid <= 1'b0;
            bus.game_rdata  <= '0;
            bus.addr_err    <= 1'b0;
            starve_cnt      <= '0;
            tag1            <= '0;
            tag2            <= '0;
        end else begin
            // Out-of-range accesses never reach the RAM but reads still return a tag.
            bus.ram_en <= any_gnt & ~sel_oor;
            bus.ram_we <= sel_we & ~sel_oor;
            if (any_gnt) begin
                bus.ram_addr  <= sel_addr;
                bus.ram_wdata <= bus.game_wdata;
            end
            if (any_gnt && sel_oor) begin
                bus.addr_err <= 1'b1;
            end

            tag1 <= '{valid: any_gnt & ~sel_we, owner: game_gnt, oor: sel_oor};
            tag2 <= tag1;

            bus.vid_rvalid  <= tag2.valid & ~tag2.owner;
            bus.game_rvalid <= tag2.valid & tag2.owner;
            if (tag2.valid && tag2.owner) begin
                bus.game_rdata <= ret_data;
            end
            if (tag2.valid && !tag2.owner) begin
                bus.vid_rdata <= ret_data;
            end

            if (game_gnt || !bus.game_req) begin
                starve_cnt <= '0;
            end else if (vid_gnt && starve_cnt < 4'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a write-first synchronous RAM model.
module tb_board_ram_arbiter;
    logic clk_pix = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    board_ram_arbiter_if #(.AW(8), .DW(3)) bus ();

    board_ram_arbiter #(
        .CELLS(200),
        .AW(8),
        .DW(3),
        .STARVE_MAX(4)
    ) dut (
        .clk_pix(clk_pix),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk_pix = ~clk_pix;

    // RAM model: cell = addr mod 8 at start, read data valid the cycle after ram_en.
    logic [2:0] mem [256];
    logic       loaded = 1'b0;
    always @(posedge clk_pix) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 3'(i % 8);
            loaded <= 1'b1;
        end else if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_wdata;
                bus.ram_rdata     <= bus.ram_wdata;
            end else begin
                bus.ram_rdata <= mem[bus.ram_addr];
            end
        end
    end

    typedef struct {
        logic vr;
        logic gr;
        logic exp_vg;
        logic exp_gg;
        int   exp_cnt;
    } arb_vec_t;

    arb_vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic idle_in();
        bus.vid_req    = 1'b0;
        bus.vid_addr   = '0;
        bus.game_req   = 1'b0;
        bus.game_we    = 1'b0;
        bus.game_addr  = '0;
        bus.game_wdata = '0;
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_ram_en"}, 32'(bus.ram_en), 0);
        chk({tag, "_ram_we"}, 32'(bus.ram_we), 0);
        chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 0);
        chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 0);
        chk({tag, "_vid_rvalid"}, 32'(bus.vid_rvalid), 0);
        chk({tag, "_vid_rdata"}, 32'(bus.vid_rdata), 0);
        chk({tag, "_game_rvalid"}, 32'(bus.game_rvalid), 0);
        chk({tag, "_game_rdata"}, 32'(bus.game_rdata), 0);
        chk({tag, "_addr_err"}, 32'(bus.addr_err), 0);
    endtask

    initial begin
        logic prev_any;

        // Both requesters busy: V,V,V,V,G repeating; single-requester and idle cycles clear it.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 2};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 3};
        tbl[23] = '{1'b1, 1'b1, 1'b0, 1'b1, 4};

        // Reset with both requests pending: no grants, registers cleared.
        rst = 1'b1;
        idle_in();
        bus.vid_req  = 1'b1;
        bus.game_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_pix);
            chk("rst_vid_gnt", 32'(bus.vid_gnt), 0);
            chk("rst_game_gnt", 32'(bus.game_gnt), 0);
            if (c == 2) chk_regs_zero("rst");
            next_cycle();
        end
        rst = 1'b0;
        idle_in();
        next_cycle();

        // Video-only stream over all cells.
        for (int c = 0; c < 205; c++) begin
            if (c < 200) begin
                bus.vid_req  = 1'b1;
                bus.vid_addr = 8'(c);
            end else begin
                bus.vid_req = 1'b0;
            end
            @(negedge clk_pix);
            if (c < 200) chk("stream_vid_gnt", 32'(bus.vid_gnt), 1);
            chk("stream_ram_en", 32'(bus.ram_en), 32'(c >= 1 && c <= 200));
            chk("stream_vid_rvalid", 32'(bus.vid_rvalid), 32'(c >= 3 && c <= 202));
            if (c >= 3 && c <= 202) chk("stream_vid_rdata", 32'(bus.vid_rdata), 32'((c - 3) % 8));
            chk("stream_game_rvalid", 32'(bus.game_rvalid), 0);
            next_cycle();
        end
        idle_in();
        for (int c = 0; c < 3; c++) next_cycle();

        // Arbitration / starvation table.
        bus.vid_addr  = 8'd3;
        bus.game_addr = 8'd5;
        prev_any      = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bus.vid_req  = tbl[i].vr;
            bus.game_req = tbl[i].gr;
            @(negedge clk_pix);
            chk($sformatf("arb%0d_vid_gnt", i), 32'(bus.vid_gnt), 32'(tbl[i].exp_vg));
            chk($sformatf("arb%0d_game_gnt", i), 32'(bus.game_gnt), 32'(tbl[i].exp_gg));
            chk($sformatf("arb%0d_starve_cnt", i), 32'(dut.starve_cnt), 32'(tbl[i].exp_cnt));
            chk($sformatf("arb%0d_ram_en", i), 32'(bus.ram_en), 32'(prev_any));
            prev_any = tbl[i].exp_vg | tbl[i].exp_gg;
            next_cycle();
        end
        idle_in();
        for (int c = 0; c < 4; c++) next_cycle();

        // Game write 5 -> 37, then game read 37.
        for (int c = 0; c < 7; c++) begin
            idle_in();
            if (c <= 1) begin
                bus.game_req   = 1'b1;
                bus.game_we    = (c == 0);
                bus.game_addr  = 8'd37;
                bus.game_wdata = 3'd5;
            end
            @(negedge clk_pix);
            if (c <= 1) chk("wr_game_gnt", 32'(bus.game_gnt), 1);
            chk("wr_ram_we", 32'(bus.ram_we), 32'(c == 1));
            if (c == 1) chk("wr_ram_addr", 32'(bus.ram_addr), 37);
            if (c == 1) chk("wr_ram_wdata", 32'(bus.ram_wdata), 5);
            chk("rd_game_rvalid", 32'(bus.game_rvalid), 32'(c == 4));
            if (c == 4) chk("rd_game_rdata", 32'(bus.game_rdata), 5);
            chk("wr_vid_rvalid", 32'(bus.vid_rvalid), 0);
            next_cycle();
        end

        // Game write 6 -> 50, video read of 50 the next cycle.
        for (int c = 0; c < 6; c++) begin
            idle_in();
            if (c == 0) begin
                bus.game_req   = 1'b1;
                bus.game_we    = 1'b1;
                bus.game_addr  = 8'd50;
                bus.game_wdata = 3'd6;
            end
            if (c == 1) begin
                bus.vid_req  = 1'b1;
                bus.vid_addr = 8'd50;
            end
            @(negedge clk_pix);
            if (c == 1) chk("raw_vid_gnt", 32'(bus.vid_gnt), 1);
            chk("raw_vid_rvalid", 32'(bus.vid_rvalid), 32'(c == 4));
            if (c == 4) chk("raw_vid_rdata", 32'(bus.vid_rdata), 6);
            next_cycle();
        end

        // Out-of-range game read of 200.
        for (int c = 0; c < 7; c++) begin
            idle_in();
            if (c == 0) begin
                bus.game_req  = 1'b1;
                bus.game_addr = 8'd200;
            end
            @(negedge clk_pix);
            if (c == 0) chk("oor_game_gnt", 32'(bus.game_gnt), 1);
            chk("oor_ram_en", 32'(bus.ram_en), 0);
            chk("oor_addr_err", 32'(bus.addr_err), 32'(c >= 1));
            chk("oor_game_rvalid", 32'(bus.game_rvalid), 32'(c == 3));
            if (c == 3) chk("oor_game_rdata", 32'(bus.game_rdata), 0);
            next_cycle();
        end

        // Reads in flight when rst pulses are discarded; a fresh read returns normally.
        for (int c = 0; c < 9; c++) begin
            idle_in();
            rst = (c == 2);
            if (c <= 3) begin
                bus.vid_req  = 1'b1;
                bus.vid_addr = 8'(10 + c);
            end
            @(negedge clk_pix);
            if (c == 2) chk("mid_rst_vid_gnt", 32'(bus.vid_gnt), 0);
            if (c == 3) begin
                chk_regs_zero("post_rst");
                chk("post_rst_vid_gnt", 32'(bus.vid_gnt), 1);
            end
            chk("mid_rst_vid_rvalid", 32'(bus.vid_rvalid), 32'(c == 6));
            if (c == 6) chk("mid_rst_vid_rdata", 32'(bus.vid_rdata), 5);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
